dmem_req_ctrl: RTL and testbench

- Data-memory request controller between the core's memory stage and the data memory.
- Converts LW/LBU/SW/SB requests into the core-to-memory packet (write_data, valid, wen, byte_not_word, yumi).
- Tracks the memory-to-core response packet (read_data, valid, yumi) using the states DMEM_IDLE, DMEM_REQ_SENT and DMEM_REQ_ACKED.
- Stalls the pipeline until each access completes, returns load data (LBU zero-extended), and flags a memory timeout.

---
 rtl/dmem_req_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_dmem_req_ctrl.sv | 423 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_req_ctrl.sv
// dmem_req_ctrl: data-memory request controller between the memory stage
// and the data memory. Issues one command per LW/LBU/SW/SB, stalls the
// pipeline until it completes, returns load data, flags memory timeouts.
//
// Ports:
//   clk, n_reset          clock, synchronous active-low reset
//   req_valid_i           memory-stage instruction is a load/store
//   is_store_i, byte_i    SW/SB vs LW/LBU, byte vs word
//   addr_i, wdata_i       byte address, store data
//   mem_*_o               core-to-memory packet (addr, data, valid, wen,
//                         byte_not_word, yumi)
//   mem_rdata_i           memory read word
//   mem_valid_i           read data present
//   mem_ack_i             memory accepted the command
//   stall_o               hold the pipeline
//   rdata_o               load result
//   resp_valid_o          one-cycle completion pulse
//   err_o                 sticky timeout flag
module dmem_req_ctrl #(
    parameter int unsigned timeout_p   = 256,
    parameter int unsigned cnt_width_p = 9
) (
    input  logic        clk,
    input  logic        n_reset,
    input  logic        req_valid_i,
    input  logic        is_store_i,
    input  logic        byte_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic        mem_valid_o,
    output logic        mem_wen_o,
    output logic        mem_byte_o,
    output logic        mem_yumi_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_valid_i,
    input  logic        mem_ack_i,
    output logic        stall_o,
    output logic [31:0] rdata_o,
    output logic        resp_valid_o,
    output logic        err_o
);

    typedef enum logic [1:0] {
        DMEM_IDLE,
        DMEM_REQ_SENT,
        DMEM_REQ_ACKED
    } dmem_state_e;

    localparam logic [cnt_width_p-1:0] CntMax =
        cnt_width_p'(timeout_p - 1);
    localparam logic [cnt_width_p-1:0] CntOne =
        cnt_width_p'(1);

    dmem_state_e            state_q, state_d;
    logic [cnt_width_p-1:0] cnt_q, cnt_d;
    logic [31:0]            addr_q, addr_d;
    logic [31:0]            wdata_q, wdata_d;
    logic [31:0]            rdata_q, rdata_d;
    logic                   wen_q, wen_d;
    logic                   byte_q, byte_d;
    logic                   resp_q, resp_d;
    logic                   err_q, err_d;
    logic                   yumi;
    logic [7:0]             lane_byte;
    logic [31:0]            load_data;

    // Little-endian lane select for LBU.
    always_comb begin
        unique case (addr_q[1:0])
            2'd0: lane_byte = mem_rdata_i[7:0];
            2'd1: lane_byte = mem_rdata_i[15:8];
            2'd2: lane_byte = mem_rdata_i[23:16];
            2'd3: lane_byte = mem_rdata_i[31:24];
        endcase
    end

    assign load_data = byte_q ? {24'b0, lane_byte} : mem_rdata_i;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wen_d   = wen_q;
        byte_d  = byte_q;
        rdata_d = rdata_q;
        resp_d  = 1'b0;
        err_d   = err_q;
        yumi    = 1'b0;
        unique case (state_q)
            DMEM_IDLE: begin
                // The pulse cycle still shows the finished instruction,
                // so it must not be taken as a new request.
                if (req_valid_i && !resp_q) begin
                    addr_d  = addr_i;
                    wdata_d = byte_i ? {4{wdata_i[7:0]}} : wdata_i;
                    wen_d   = is_store_i;
                    byte_d  = byte_i;
                    state_d = DMEM_REQ_SENT;
                end
            end
            DMEM_REQ_SENT: begin
                if (mem_ack_i) begin
                    if (wen_q) begin
                        state_d = DMEM_IDLE;
                        resp_d  = 1'b1;
                    end else if (mem_valid_i) begin
                        yumi    = 1'b1;
                        rdata_d = load_data;
                        state_d = DMEM_IDLE;
                        resp_d  = 1'b1;
                    end else begin
                        state_d = DMEM_REQ_ACKED;
                    end
                end else if (cnt_q == CntMax) begin
                    err_d   = 1'b1;
                    state_d = DMEM_IDLE;
                    resp_d  = 1'b1;
                end
            end
            DMEM_REQ_ACKED: begin
                if (mem_valid_i) begin
                    yumi    = 1'b1;
                    rdata_d = load_data;
                    state_d = DMEM_IDLE;
                    resp_d  = 1'b1;
                end else if (cnt_q == CntMax) begin
                    err_d   = 1'b1;
                    state_d = DMEM_IDLE;
                    resp_d  = 1'b1;
                end
            end
            default: begin
                state_d = DMEM_IDLE;
            end
        endcase
        // Counts cycles spent waiting in one state; any move restarts it.
        if (state_d != state_q || state_q == DMEM_IDLE) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CntOne;
        end
    end

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state_q <= DMEM_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wen_q   <= 1'b0;
            byte_q  <= 1'b0;
            rdata_q <= '0;
            resp_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wen_q   <= wen_d;
            byte_q  <= byte_d;
            rdata_q <= rdata_d;
            resp_q  <= resp_d;
            err_q   <= err_d;
        end
    end

    assign mem_addr_o   = addr_q;
    assign mem_wdata_o  = wdata_q;
    assign mem_wen_o    = wen_q;
    assign mem_byte_o   = byte_q;
    assign mem_valid_o  = (state_q == DMEM_REQ_SENT);
    assign mem_yumi_o   = yumi;
    assign rdata_o      = rdata_q;
    assign resp_valid_o = resp_q;
    assign err_o        = err_q;
    assign stall_o      = (state_q != DMEM_IDLE) |
                          (req_valid_i & ~resp_q);

endmodule

// File: tb/tb_dmem_req_ctrl.sv
// tb_dmem_req_ctrl: scoreboard bench for dmem_req_ctrl with a
// behavioural memory responder and a queue-based reference model.
module tb_dmem_req_ctrl;

    localparam int TO = 256;
    localparam int P_IDLE  = 0;
    localparam int P_ACK   = 1;
    localparam int P_VLD   = 2;
    localparam int P_DONE  = 3;
    localparam int P_STRAY = 4;

    logic        clk;
    logic        n_reset;
    logic        req_valid_i;
    logic        is_store_i;
    logic        byte_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_valid_o;
    logic        mem_wen_o;
    logic        mem_byte_o;
    logic        mem_yumi_o;
    logic [31:0] mem_rdata_i;
    logic        mem_valid_i;
    logic        mem_ack_i;
    logic        stall_o;
    logic [31:0] rdata_o;
    logic        resp_valid_o;
    logic        err_o;

    dmem_req_ctrl dut (
        .clk          (clk),
        .n_reset      (n_reset),
        .req_valid_i  (req_valid_i),
        .is_store_i   (is_store_i),
        .byte_i       (byte_i),
        .addr_i       (addr_i),
        .wdata_i      (wdata_i),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_valid_o  (mem_valid_o),
        .mem_wen_o    (mem_wen_o),
        .mem_byte_o   (mem_byte_o),
        .mem_yumi_o   (mem_yumi_o),
        .mem_rdata_i  (mem_rdata_i),
        .mem_valid_i  (mem_valid_i),
        .mem_ack_i    (mem_ack_i),
        .stall_o      (stall_o),
        .rdata_o      (rdata_o),
        .resp_valid_o (resp_valid_o),
        .err_o        (err_o)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        wen;
        logic        bt;
    } cmd_t;

    typedef struct {
        int ack_dly;
        int vld_dly;
        bit no_ack;
        bit no_vld;
    } plan_t;

    exp_t  exp_q[$];
    cmd_t  cmd_q[$];
    plan_t plan_q[$];

    int compared   = 0;
    int mismatched = 0;
    int episodes   = 0;
    int issued     = 0;
    int cyc        = 0;

    logic [31:0] ref_mem  [64];
    logic [31:0] resp_mem [64];
    logic [31:0] last_m;
    logic        err_m;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [95:0] act,
                       input logic [95:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic summary();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    endtask

    // Reference model: decides each access's outcome from the memory
    // plan and the architectural memory image, at issue time.
    function automatic void issue(input bit st, input bit bt,
                                  input logic [31:0] a,
                                  input logic [31:0] w,
                                  input int ad, input int vd,
                                  input bit na, input bit nv);
        cmd_t        c;
        plan_t       p;
        exp_t        e;
        logic [31:0] word;
        int          idx;
        int          lane;
        idx  = int'(a[7:2]);
        lane = int'(a[1:0]);
        c.addr    = a;
        c.wdata   = bt ? {4{w[7:0]}} : w;
        c.wen     = st;
        c.bt      = bt;
        p.ack_dly = ad;
        p.vld_dly = vd;
        p.no_ack  = na;
        p.no_vld  = nv;
        if (na || (!st && nv)) begin
            err_m   = 1'b1;
            e.rdata = last_m;
            e.err   = 1'b1;
            e.cyc   = na ? cyc + 1 + TO : cyc + 2 + ad + TO;
        end else if (st) begin
            if (bt) begin
                word = ref_mem[idx];
                word[lane*8 +: 8] = w[7:0];
                ref_mem[idx] = word;
            end else begin
                ref_mem[idx] = w;
            end
            e.rdata = last_m;
            e.err   = err_m;
            e.cyc   = cyc + 2 + ad;
        end else begin
            word   = ref_mem[idx];
            last_m = bt ? ((word >> (8 * lane)) & 32'hFF) : word;
            e.rdata = last_m;
            e.err   = err_m;
            e.cyc   = cyc + 2 + ad + vd;
        end
        issued++;
        cmd_q.push_back(c);
        plan_q.push_back(p);
        exp_q.push_back(e);
    endfunction

    task automatic drive_req(input bit st, input bit bt,
                             input logic [31:0] a, input logic [31:0] w);
        req_valid_i = 1'b1;
        is_store_i  = st;
        byte_i      = bt;
        addr_i      = a;
        wdata_i     = w;
    endtask

    task automatic drive_idle();
        req_valid_i = 1'b0;
        is_store_i  = 1'($urandom);
        byte_i      = 1'($urandom);
        addr_i      = $urandom;
        wdata_i     = $urandom;
    endtask

    // Called right after a falling edge; returns at a falling edge
    // after the instruction has retired.
    task automatic access(input bit st, input bit bt,
                          input logic [31:0] a, input logic [31:0] w,
                          input int ad, input int vd,
                          input bit na, input bit nv);
        int n;
        issue(st, bt, a, w, ad, vd, na, nv);
        drive_req(st, bt, a, w);
        n = 0;
        #1;
        while (stall_o === 1'b1 && n < 700) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 700) begin
            compared++;
            mismatched++;
            $display("FAIL stall_bound: stall_o=%b after %0d cycles, need 0",
                     stall_o, n);
            summary();
        end
        chk("stall_release_with_resp", resp_valid_o, 1'b1);
        @(negedge clk);
        drive_idle();
    endtask

    task automatic do_reset(input int cycles);
        n_reset     = 1'b0;
        req_valid_i = 1'b0;
        repeat (cycles) @(negedge clk);
        #1;
        chk("rst_flags",
            {mem_valid_o, mem_wen_o, mem_byte_o, mem_yumi_o,
             resp_valid_o, err_o, stall_o}, 7'b0);
        chk("rst_mem_addr", mem_addr_o, 32'h0);
        chk("rst_mem_wdata", mem_wdata_o, 32'h0);
        chk("rst_rdata", rdata_o, 32'h0);
        exp_q.delete();
        last_m = 32'h0;
        err_m  = 1'b0;
        @(negedge clk);
        n_reset = 1'b1;
        @(negedge clk);
    endtask

    // Response monitor.
    initial begin : resp_monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (n_reset === 1'b1 && resp_valid_o === 1'b1) begin
                if (exp_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_resp: got pulse, need none");
                end else begin
                    e = exp_q.pop_front();
                    chk("resp_rdata", rdata_o, e.rdata);
                    chk("resp_err", err_o, e.err);
                    chk("resp_cycle", cyc, e.cyc);
                    chk("resp_stall", stall_o, 1'b0);
                end
            end
        end
    end

    // Memory responder.
    initial begin : responder
        plan_t       pl;
        cmd_t        cm;
        int          phase;
        int          cnt;
        int          idx;
        int          lane;
        logic        ack;
        logic        vld;
        logic        ey;
        logic [31:0] rd;
        phase = P_IDLE;
        cnt   = 0;
        mem_ack_i   = 1'b0;
        mem_valid_i = 1'b0;
        mem_rdata_i = 32'h0;
        forever begin
            @(negedge clk);
            ack = 1'b0;
            vld = 1'b0;
            ey  = 1'b0;
            rd  = $urandom;
            idx  = int'(mem_addr_o[7:2]);
            lane = int'(mem_addr_o[1:0]);
            if (n_reset !== 1'b1) begin
                phase = P_IDLE;
                plan_q.delete();
                cmd_q.delete();
            end else begin
                if (phase == P_DONE) phase = P_IDLE;
                if (phase == P_STRAY && mem_valid_o !== 1'b1) phase = P_IDLE;
                if (phase == P_IDLE && mem_valid_o === 1'b1) begin
                    episodes++;
                    if (plan_q.size() == 0 || cmd_q.size() == 0) begin
                        compared++;
                        mismatched++;
                        $display("FAIL stray_request: addr %0h, need none",
                                 mem_addr_o);
                        phase = P_STRAY;
                    end else begin
                        pl    = plan_q.pop_front();
                        cm    = cmd_q.pop_front();
                        cnt   = pl.ack_dly;
                        phase = P_ACK;
                    end
                end
                if (phase == P_ACK) begin
                    if (resp_valid_o === 1'b1) begin
                        phase = P_IDLE;
                    end else begin
                        chk("req_fields",
                            {mem_valid_o, mem_wen_o, mem_byte_o,
                             mem_addr_o, mem_wdata_o},
                            {1'b1, cm.wen, cm.bt, cm.addr, cm.wdata});
                        if (!pl.no_ack && cnt == 0) begin
                            ack = 1'b1;
                            if (cm.wen) begin
                                if (mem_byte_o)
                                    resp_mem[idx][lane*8 +: 8] =
                                        mem_wdata_o[lane*8 +: 8];
                                else
                                    resp_mem[idx] = mem_wdata_o;
                                phase = P_DONE;
                            end else if (!pl.no_vld && pl.vld_dly == 0) begin
                                vld   = 1'b1;
                                rd    = resp_mem[idx];
                                ey    = 1'b1;
                                phase = P_DONE;
                            end else begin
                                cnt   = pl.vld_dly - 1;
                                phase = P_VLD;
                            end
                        end else begin
                            cnt--;
                            if ($urandom_range(0, 2) == 0) begin
                                vld = 1'b1;
                                rd  = 32'hBAD0_BAD0;
                            end
                        end
                    end
                end else if (phase == P_VLD) begin
                    if (resp_valid_o === 1'b1) begin
                        phase = P_IDLE;
                    end else begin
                        chk("acked_valid_low", mem_valid_o, 1'b0);
                        if (!pl.no_vld && cnt == 0) begin
                            vld   = 1'b1;
                            rd    = resp_mem[idx];
                            ey    = 1'b1;
                            phase = P_DONE;
                        end else begin
                            cnt--;
                        end
                    end
                end
            end
            mem_ack_i   = ack;
            mem_valid_i = vld;
            mem_rdata_i = rd;
            #1;
            if (n_reset === 1'b1) chk("yumi", mem_yumi_o, ey);
        end
    end

    initial begin : watchdog
        #1_000_000;
        compared++;
        mismatched++;
        $display("FAIL watchdog: run still active at %0t, need finish",
                 $time);
        summary();
    end

    initial begin : stimulus
        bit          st;
        bit          bt;
        logic [31:0] a;
        logic [31:0] w;
        for (int i = 0; i < 64; i++) begin
            ref_mem[i]  = (i * 32'h0101_0101) ^ 32'h5A3C_9600;
            resp_mem[i] = (i * 32'h0101_0101) ^ 32'h5A3C_9600;
        end
        ref_mem[32]  = 32'h1234_5678;
        resp_mem[32] = 32'h1234_5678;
        last_m = 32'h0;
        err_m  = 1'b0;
        n_reset = 1'b0;
        drive_idle();
        @(negedge clk);
        do_reset(3);

        access(1, 0, 32'h40, 32'hDEAD_BEEF, 0, 0, 0, 0);
        access(0, 0, 32'h80, 32'h0, 0, 0, 0, 0);
        access(1, 0, 32'h80, 32'hAABB_CCDD, 1, 0, 0, 0);
        access(0, 1, 32'h83, 32'h0, 0, 3, 0, 0);
        access(1, 1, 32'h05, 32'h1234_5677, 2, 0, 0, 0);
        access(0, 1, 32'h05, 32'h0, 1, 1, 0, 0);
        access(0, 1, 32'h06, 32'h0, 0, 0, 0, 0);

        access(1, 0, 32'h44, 32'h0BAD_F00D, 0, 0, 1, 0);
        access(0, 0, 32'h40, 32'h0, 0, 0, 0, 0);
        access(0, 0, 32'h44, 32'h0, 0, 0, 0, 0);
        access(0, 0, 32'h48, 32'h0, 1, 0, 0, 1);

        issue(0, 1, 32'h88, 32'h0, 0, 0, 0, 1);
        drive_req(0, 1, 32'h88, 32'h0);
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("acked_state", {mem_valid_o, stall_o}, 2'b01);
        do_reset(1);

        access(0, 0, 32'h40, 32'h0, 0, 0, 0, 0);
        access(1, 0, 32'h4C, 32'hCAFE_0001, 0, 0, 0, 0);
        access(0, 0, 32'h4C, 32'h0, 2, 2, 0, 0);

        repeat (150) begin
            st = 1'($urandom);
            bt = 1'($urandom);
            a  = {24'b0, 8'($urandom)};
            if (!bt) a[1:0] = 2'b00;
            w  = $urandom;
            access(st, bt, a, w, $urandom_range(0, 4),
                   $urandom_range(0, 4), 0, 0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        chk("episodes", episodes, issued);
        chk("exp_q_empty", exp_q.size(), 0);
        chk("plan_q_empty", plan_q.size(), 0);
        summary();
    end

endmodule
